uart_dpram_sched: RTL and testbench

- Owns port 2 of the data dual-port RAM and time-shares it between three requesters: RX byte delivery, status-word refresh, and TX byte fetch.
- Buffers received bytes in a small FIFO so the CPU may lag the line.
- Sequences the uart_tx start/ready handshake.
- Sits between uart_rx/uart_tx (50 MHz domain, levels sampled at 100 MHz) and the dpram in the top-level.

---
 rtl/uart_dpram_sched.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_dpram_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dpram_sched.sv
// uart_dpram_sched
//
// Owns port 2 of the data dual-port RAM. It time-shares that port between
// three requesters: RX byte delivery, status-word refresh and TX byte fetch.
// Received bytes are held in a small FIFO so the CPU may lag the line. The
// block also runs the uart_tx start/ready handshake.
//
// Optional build macro: UART_RX_OVERRUN_EN. When it is defined, a byte that
// arrives while the FIFO is full sets a sticky overrun flag. The flag shows
// in status bit6 and is cleared by the next RX pop. When it is undefined,
// bit6 reads 0 and the byte is dropped silently.
//
// Ports:
//   clock_100M  system clock
//   n_rst       asynchronous active-low reset
//   cpu_addr    CPU data-port address (snooped)
//   cpu_we      CPU data-port write enable (snooped)
//   ram_addr    dpram port-2 address
//   ram_din     dpram port-2 write data
//   ram_we      dpram port-2 write enable
//   ram_dout    dpram port-2 read data (1-cycle synchronous latency)
//   rx_ready    uart_rx byte-valid level
//   rx_data     uart_rx byte
//   tx_ready    uart_tx idle level
//   tx_start    uart_tx start request
//   tx_data     byte to transmit, held while a transfer is in flight
//
// Status word: bit0 = tx idle, bit1 = RX available, bits[5:2] = FIFO count,
//              bit6 = overrun, bits[15:7] = 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | pick head > status > tx request, no RAM access
// HEAD_WR  | write the FIFO head byte to RX_DATA_ADDR (skipped when empty)
// STAT_WR  | write the status word to STATUS_ADDR
// TX_RD    | present TX_DATA_ADDR for a RAM read
// TX_LAT   | RAM read data valid, latch it into tx_data
// TX_GO    | hold tx_start until uart_tx reports busy (tx_ready low)
// TX_WAIT  | single cycle back to IDLE; completion is tracked separately

module uart_dpram_sched #(
    parameter logic [11:0] STATUS_ADDR     = 12'h800,
    parameter logic [11:0] TX_DATA_ADDR    = 12'h801,
    parameter logic [11:0] RX_DATA_ADDR    = 12'h802,
    parameter logic [11:0] RX_ACK_ADDR     = 12'h803,
    parameter int          FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clock_100M,
    input  logic        n_rst,
    input  logic [11:0] cpu_addr,
    input  logic        cpu_we,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W = FIFO_DEPTH_LOG2;
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        HEAD_WR,
        STAT_WR,
        TX_RD,
        TX_LAT,
        TX_GO,
        TX_WAIT
    } state_t;

    state_t state, state_nxt;

    logic             rx_prev;
    logic             rx_rise;
    logic             pop_req;
    logic             pop_ok;
    logic             push_ok;
    logic             tx_req;
    logic             tx_done;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [7:0]       fifo_head;
    logic             status_dirty;
    logic             head_dirty;
    logic             tx_pend;
    logic             tx_busy;
    logic             tx_low_seen;
    logic             overrun;
    logic [15:0]      status_word;
    logic             unused_dout_hi;

    // Only the low byte of a RAM word carries TX data.
    assign unused_dout_hi = ^ram_dout[15:8];

    assign rx_rise    = rx_ready & ~rx_prev;
    assign pop_req    = cpu_we && (cpu_addr == RX_ACK_ADDR);
    assign tx_req     = cpu_we && (cpu_addr == TX_DATA_ADDR) && !tx_busy;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(DEPTH));
    assign pop_ok     = pop_req && !fifo_empty;
    // A same-cycle pop frees a slot, so the push is accepted even when full.
    assign push_ok    = rx_rise && (!fifo_full || pop_ok);
    assign fifo_head  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    // Completion: first tx_ready high after uart_tx acknowledged the start.
    assign tx_done    = tx_busy && tx_low_seen && tx_ready;

    assign status_word = {9'b0, overrun, 4'(fifo_cnt), ~fifo_empty, ~tx_busy};

    // rx_prev resets high so a level already present at reset is not a byte.
    always_ff @(posedge clock_100M or negedge n_rst) begin
        if (!n_rst) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_ready;
        end
    end

    always_ff @(posedge clock_100M) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clock_100M or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef UART_RX_OVERRUN_EN
    always_ff @(posedge clock_100M or negedge n_rst) begin
        if (!n_rst) begin
            overrun <= 1'b0;
        end else if (pop_req) begin
            overrun <= 1'b0;
        end else if (rx_rise && !push_ok) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

    // Dirty flags: a new event in the servicing cycle keeps the flag set.
    always_ff @(posedge clock_100M or negedge n_rst) begin
        if (!n_rst) begin
            status_dirty <= 1'b1;
            head_dirty   <= 1'b0;
            tx_pend      <= 1'b0;
            tx_busy      <= 1'b0;
            tx_low_seen  <= 1'b0;
            tx_data      <= 8'h00;
        end else begin
            status_dirty <= rx_rise | pop_req | tx_req | tx_done
                          | (status_dirty & (state != STAT_WR));
            head_dirty   <= (push_ok & fifo_empty) | pop_req
                          | (head_dirty & (state != HEAD_WR));
            tx_pend      <= tx_req | (tx_pend & (state != TX_RD));

            if (tx_req) begin
                tx_busy <= 1'b1;
            end else if (tx_done) begin
                tx_busy <= 1'b0;
            end

            if (tx_done) begin
                tx_low_seen <= 1'b0;
            end else if ((state == TX_GO) && !tx_ready) begin
                tx_low_seen <= 1'b1;
            end

            if (state == TX_LAT) begin
                tx_data <= ram_dout[7:0];
            end
        end
    end

    always_ff @(posedge clock_100M or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode straight from the state so reset clears tx_start at once.
    always_comb begin
        state_nxt = state;
        ram_addr  = STATUS_ADDR;
        ram_din   = 16'h0000;
        ram_we    = 1'b0;
        tx_start  = 1'b0;
        case (state)
            IDLE: begin
                if (head_dirty) begin
                    state_nxt = HEAD_WR;
                end else if (status_dirty) begin
                    state_nxt = STAT_WR;
                end else if (tx_pend) begin
                    state_nxt = TX_RD;
                end
            end
            HEAD_WR: begin
                ram_addr  = RX_DATA_ADDR;
                ram_din   = {8'h00, fifo_head};
                ram_we    = ~fifo_empty;
                state_nxt = IDLE;
            end
            STAT_WR: begin
                ram_addr  = STATUS_ADDR;
                ram_din   = status_word;
                ram_we    = 1'b1;
                state_nxt = IDLE;
            end
            TX_RD: begin
                ram_addr  = TX_DATA_ADDR;
                state_nxt = TX_LAT;
            end
            TX_LAT: begin
                state_nxt = TX_GO;
            end
            TX_GO: begin
                tx_start = 1'b1;
                if (!tx_ready) begin
                    state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_dpram_sched.sv
// Bench for uart_dpram_sched: a RAM model with a write log, a uart_tx responder
// and a queue-based reference model of the FIFO/status/TX behaviour.
`timescale 1ns/1ps

module tb_uart_dpram_sched;

    logic        clock_100M = 1'b0;
    logic        n_rst      = 1'b0;
    logic [11:0] cpu_addr   = 12'h000;
    logic        cpu_we     = 1'b0;
    logic [15:0] cpu_wdata  = 16'h0000;
    logic [11:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout   = 16'h0000;
    logic        rx_ready   = 1'b0;
    logic [7:0]  rx_data    = 8'h00;
    logic        tx_ready   = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;

    always #5 clock_100M = ~clock_100M;

    uart_dpram_sched dut (
        .clock_100M (clock_100M),
        .n_rst      (n_rst),
        .cpu_addr   (cpu_addr),
        .cpu_we     (cpu_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data)
    );

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    logic [15:0] mem [0:4095];
    wr_t         wlog [$];
    logic [7:0]  txlog [$];
    int          cyc = 0;
    logic        resp_busy = 1'b0;
    int          resp_d = 0;
    int          resp_l = 0;

    // Dual-port RAM: port 1 is the CPU, port 2 is the DUT.
    always @(posedge clock_100M) begin
        wr_t e;
        cyc <= cyc + 1;
        if (cpu_we) mem[cpu_addr] <= cpu_wdata;
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            e.cyc  = cyc;
            e.addr = ram_addr;
            e.data = ram_din;
            wlog.push_back(e);
        end
        ram_dout <= mem[ram_addr];
    end

    // uart_tx stand-in: accepts a start after 0..2 cycles, stays busy 4..8.
    always begin
        @(posedge clock_100M);
        #1;
        if (n_rst && tx_start && tx_ready) begin
            resp_busy = 1'b1;
            resp_d = $urandom_range(0, 2);
            resp_l = $urandom_range(4, 8);
            repeat (resp_d) @(posedge clock_100M);
            #1 tx_ready = 1'b0;
            txlog.push_back(tx_data);
            repeat (resp_l) @(posedge clock_100M);
            #1 tx_ready = 1'b1;
            resp_busy = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 500000", $time);
        $fatal(1, "watchdog");
    end

    // Reference model state.
    logic [7:0] q [$];
    bit         m_busy = 1'b0;
    bit         m_ovr  = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         rx_cyc  = 0;

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        s = 16'h0000;
        s[0]   = !m_busy;
        s[1]   = (q.size() != 0);
        s[5:2] = 4'(q.size());
        s[6]   = m_ovr;
        return s;
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (q.size() < 4) q.push_back(b);
`ifdef UART_RX_OVERRUN_EN
        else m_ovr = 1'b1;
`endif
    endtask

    task automatic m_pop();
        if (q.size() != 0) void'(q.pop_front());
        m_ovr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clock_100M);
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clock_100M);
        rx_data  = b;
        rx_ready = 1'b1;
        rx_cyc   = cyc;
        @(negedge clock_100M);
        rx_ready = 1'b0;
        m_push(b);
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        @(negedge clock_100M);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(negedge clock_100M);
        cpu_we    = 1'b0;
    endtask

    task automatic wait_tx(input int n_exp);
        int t;
        t = 0;
        while ((txlog.size() < n_exp || resp_busy) && t < 200) begin
            @(negedge clock_100M);
            t++;
        end
        chk("tx_done_in_time", t < 200, 1);
        m_busy = 1'b0;
        settle(12);
    endtask

    task automatic check_ram(input string tag);
        chk({tag, "_status"}, mem[12'h800], exp_status());
        if (q.size() != 0) chk({tag, "_head"}, mem[12'h802], {8'h00, q[0]});
    endtask

    task automatic wait_start(input string tag);
        int t;
        t = 0;
        while (!tx_start && t < 30) begin
            @(negedge clock_100M);
            t++;
        end
        chk(tag, tx_start, 1);
    endtask

    initial begin
        int head_t;
        int rd_t;
        int n_tx;
        int op;
        logic [7:0] b;

        n_tx = 0;
        // Reset values.
        settle(3);
        chk("rst_ram_addr", ram_addr, 12'h800);
        chk("rst_ram_din", ram_din, 16'h0000);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        n_rst = 1'b1;
        settle(15);
        chk("boot_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) chk("boot_write", {wlog[0].addr, wlog[0].data}, {12'h800, 16'h0001});
        wlog.delete();
        settle(10);
        chk("boot_quiet", wlog.size(), 0);

        // Single byte: head write then status.
        rx_push(8'h41);
        settle(10);
        chk("rx1_nwrites", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            chk("rx1_head", {wlog[0].addr, wlog[0].data}, {12'h802, 16'h0041});
            chk("rx1_latency_le3", (wlog[0].cyc - rx_cyc) <= 3, 1);
            chk("rx1_status", {wlog[1].addr, wlog[1].data}, {12'h800, 16'h0007});
        end
        check_ram("rx1");

        // Two bytes and one pop.
        cpu_write(12'h803, 16'h0000); m_pop(); settle(10);
        rx_push(8'h10); settle(6);
        rx_push(8'h20); settle(6);
        cpu_write(12'h803, 16'h0000); m_pop(); settle(10);
        chk("pop_head", mem[12'h802], 16'h0020);
        chk("pop_status", mem[12'h800], 16'h0007);
        check_ram("pop");
        cpu_write(12'h803, 16'h0000); m_pop(); settle(10);

        // TX byte 0x55; a second write while busy must be ignored.
        wlog.delete();
        cpu_write(12'h801, 16'h0055); m_busy = 1'b1;
        wait_start("tx1_start_seen");
        chk("tx1_data", tx_data, 8'h55);
        if (wlog.size() > 0) chk("tx1_busy_status", {wlog[0].addr, wlog[0].data}, {12'h800, 16'h0000});
        else chk("tx1_busy_status_present", wlog.size(), 1);
        cpu_write(12'h801, 16'h0099);
        head_t = 0;
        while (tx_start && head_t < 30) begin
            @(negedge clock_100M);
            head_t++;
        end
        chk("tx1_start_until_ready_low", tx_ready, 0);
        n_tx = 1;
        wait_tx(1);
        chk("tx1_count", txlog.size(), 1);
        if (txlog.size() > 0) chk("tx1_byte", txlog[0], 8'h55);
        chk("tx1_data_held", tx_data, 8'h55);
        if (wlog.size() > 0) chk("tx1_done_status", {wlog[$].addr, wlog[$].data}, {12'h800, 16'h0001});
        check_ram("tx1");

        // RX edge and TX request in the same cycle: head write must come first.
        @(negedge clock_100M);
        rx_data = 8'h3C; rx_ready = 1'b1;
        cpu_addr = 12'h801; cpu_wdata = 16'h00A7; cpu_we = 1'b1;
        m_push(8'h3C); m_busy = 1'b1;
        @(negedge clock_100M);
        rx_ready = 1'b0; cpu_we = 1'b0;
        head_t = -1; rd_t = -1;
        for (int t = 0; t < 30 && rd_t < 0; t++) begin
            if (ram_we && ram_addr == 12'h802 && head_t < 0) head_t = t;
            if (!ram_we && ram_addr == 12'h801) rd_t = t;
            @(negedge clock_100M);
        end
        chk("both_head_seen", head_t >= 0, 1);
        chk("both_head_before_txrd", (head_t >= 0) && (rd_t > head_t), 1);
        n_tx = 2;
        wait_tx(2);
        if (txlog.size() >= 2) chk("both_tx_byte", txlog[1], 8'hA7);
        else chk("both_tx_count", txlog.size(), 2);
        check_ram("both");

        // Overflow: five pushes into a depth-4 FIFO, then a pop.
        cpu_write(12'h803, 16'h0000); m_pop(); settle(10);
        for (int i = 1; i <= 5; i++) begin
            rx_push(8'(i));
            settle(6);
        end
        settle(6);
`ifdef UART_RX_OVERRUN_EN
        chk("full_status", mem[12'h800], 16'h0053);
`else
        chk("full_status", mem[12'h800], 16'h0013);
`endif
        check_ram("full");
        cpu_write(12'h803, 16'h0000); m_pop(); settle(10);
        chk("full_pop_bit6", mem[12'h800][6], 0);
        check_ram("full_pop");

        // Randomised traffic against the model.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            b  = 8'($urandom_range(0, 255));
            if (op < 4) begin
                rx_push(b);
            end else if (op < 7) begin
                cpu_write(12'h803, 16'h0000); m_pop();
            end else if (op < 9) begin
                cpu_write(12'h801, {8'h00, b}); m_busy = 1'b1;
                n_tx++;
                wait_tx(n_tx);
                if (txlog.size() == n_tx) chk($sformatf("rnd%0d_txbyte", i), txlog[n_tx-1], b);
                else chk($sformatf("rnd%0d_txcount", i), txlog.size(), n_tx);
            end
            settle(12);
            check_ram($sformatf("rnd%0d", i));
        end

        // Reset in the middle of a transfer.
        cpu_write(12'h801, 16'h00C3); m_busy = 1'b1;
        wait_start("rst_mid_start_seen");
        #2 n_rst = 1'b0;
        #1;
        chk("rst_mid_tx_start", tx_start, 0);
        chk("rst_mid_ram_we", ram_we, 0);
        chk("rst_mid_ram_addr", ram_addr, 12'h800);
        chk("rst_mid_tx_data", tx_data, 8'h00);
        q.delete(); m_busy = 1'b0; m_ovr = 1'b0;
        settle(3);
        wlog.delete();
        n_rst = 1'b1;
        settle(15);
        chk("rst_mid_nwrites", wlog.size(), 1);
        if (wlog.size() > 0) chk("rst_mid_write", {wlog[0].addr, wlog[0].data}, {12'h800, 16'h0001});
        check_ram("rst_mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
